// File: rtl/param_input_pio.sv
// param_input_pio: Avalon-MM input PIO with synchroniser, per-bit debounce,
// edge capture (write-1-to-clear) and masked level interrupt.
module param_input_pio #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 1,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [WIDTH-1:0] s1_q, s2_q, stable_q, stable_d, mask_q, mask_d, edgecap_q, edgecap_d;
   logic [WIDTH-1:0] rise, fall, new_edges;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   logic [31:0]      readdata_d;
   logic             wr_en, unused_wd;

   assign wr_en     = chipselect & write;
   assign unused_wd = ^writedata;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (s2_q[i] == stable_q[i])
            cnt_d[i] = '0;
         else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_d[i] = s2_q[i];
            cnt_d[i]    = '0;
         end else
            cnt_d[i] = cnt_q[i] + CW'(1);
      end
      rise      = ~stable_q & stable_d;
      fall      = stable_q & ~stable_d;
      new_edges = EDGE_TYPE == 0 ? rise : EDGE_TYPE == 1 ? fall : rise | fall;
      // new edges are OR-ed in after the clear so a colliding set wins
      edgecap_d = ((wr_en && address == 2'd3) ? edgecap_q & ~writedata[WIDTH-1:0] : edgecap_q) | new_edges;
      mask_d    = (wr_en && address == 2'd1) ? writedata[WIDTH-1:0] : mask_q;
      readdata_d = address == 2'd0 ? 32'(stable_q) :
                   address == 2'd1 ? 32'(mask_q) :
                   address == 2'd3 ? 32'(edgecap_q) : 32'd0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q      <= '0;
         s2_q      <= '0;
         stable_q  <= '0;
         cnt_q     <= '{default: '0};
         mask_q    <= '0;
         edgecap_q <= '0;
         readdata  <= '0;
      end else begin
         s1_q      <= in_port;
         s2_q      <= s1_q;
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         mask_q    <= mask_d;
         edgecap_q <= edgecap_d;
         readdata  <= readdata_d;
      end
   end

   assign irq = |(edgecap_q & mask_q);
endmodule
